// File: rtl/act_dispatch_pkg.sv
// act_dispatch_pkg: shared types and constants for the activation dispatcher.
//   state_e : dispatcher FSM states
//   MODE_*  : burst distribution modes carried by cmd_mode
//   beat_t  : one input beat (two packed activation words at the default width)
package act_dispatch_pkg;

    localparam int unsigned WID_ACT_DEF = 16;

    localparam logic MODE_BCAST = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef logic [2*WID_ACT_DEF-1:0] beat_t;

endpackage

// File: rtl/act_dispatch_if.sv
// act_dispatch_if: command, input-stream and per-row drain signals of the dispatcher.
//   master : controller / upstream / row side (drives cmd_*, s_data, s_vld, act_data_in_req)
//   slave  : dispatcher side (drives cmd_rdy, s_rdy, act_data_in*, busy, done, fifo_empty)
interface act_dispatch_if #(
    parameter int unsigned N_ROW   = 3,
    parameter int unsigned WID_ACT = 16,
    parameter int unsigned WID_LEN = 12
) ();

    logic                         cmd_en;
    logic                         cmd_mode;
    logic [WID_LEN-1:0]           cmd_len;
    logic                         cmd_rdy;
    logic [2*WID_ACT-1:0]         s_data;
    logic                         s_vld;
    logic                         s_rdy;
    logic [2*WID_ACT*N_ROW-1:0]   act_data_in;
    logic [N_ROW-1:0]             act_data_in_vld;
    logic [N_ROW-1:0]             act_data_in_req;
    logic                         busy;
    logic                         done;
    logic [N_ROW-1:0]             fifo_empty;

    modport master (
        output cmd_en, cmd_mode, cmd_len, s_data, s_vld, act_data_in_req,
        input  cmd_rdy, s_rdy, act_data_in, act_data_in_vld, busy, done, fifo_empty
    );

    modport slave (
        input  cmd_en, cmd_mode, cmd_len, s_data, s_vld, act_data_in_req,
        output cmd_rdy, s_rdy, act_data_in, act_data_in_vld, busy, done, fifo_empty
    );

endinterface

// File: rtl/act_row_fifo.sv
// act_row_fifo: per-row synchronous FIFO with a registered read port.
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : write request (ignored when full)
//   full, empty       : occupancy flags from the current count
//   pop_req           : read request; dropped when empty
//   rd_data, rd_vld   : popped word and its one-cycle valid, registered
module act_row_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop_req,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld
);

    localparam int unsigned WID_PTR = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WID_PTR-1:0] wptr_q, rptr_q;
    logic [WID_PTR:0]   count_q;
    logic               do_push, do_pop;

    assign full    = (count_q == (WID_PTR+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop_req && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= do_pop;
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q  <= rptr_q + 1'b1;
                rd_data <= mem_q[rptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/act_dispatch.sv
// act_dispatch: distributes one activation stream to N_ROW row FIFOs, either broadcasting
// each beat to every row or interleaving beats round-robin, under a length-bounded command.
//   clk_l, rst : clock, asynchronous active-high reset
//   bus        : act_dispatch_if slave (command, input stream, per-row drain, status)
module act_dispatch
    import act_dispatch_pkg::*;
#(
    parameter int unsigned N_ROW      = 3,
    parameter int unsigned WID_ACT    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WID_LEN    = 12
) (
    input  logic         clk_l,
    input  logic         rst,
    act_dispatch_if.slave bus
);

    localparam int unsigned WID_BEAT = 2 * WID_ACT;
    localparam int unsigned WID_PTR  = (N_ROW > 1) ? $clog2(N_ROW) : 1;

    state_e                   state_q, state_d;
    logic                     mode_q;
    logic [WID_LEN-1:0]       len_q, cnt_q;
    logic [WID_PTR-1:0]       ptr_q;
    logic [N_ROW-1:0]         full, empty, push, row_vld;
    logic [WID_BEAT*N_ROW-1:0] row_data;
    logic                     cmd_take, accept, last_beat, s_rdy;
    logic                     cmd_rdy, busy, done;

    assign cmd_take = bus.cmd_en && (state_q == StIdle);

    // Ready depends only on state and current FIFO occupancy, never on s_vld.
    always_comb begin
        s_rdy = 1'b0;
        if (state_q == StRun) begin
            s_rdy = (mode_q == MODE_BCAST) ? ~|full : ~full[ptr_q];
        end
    end

    assign accept    = bus.s_vld && s_rdy;
    assign last_beat = accept && (cnt_q == len_q - WID_LEN'(1));

    // State register
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_en) begin
                    state_d = (bus.cmd_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_beat) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_rdy = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_rdy = 1'b1;
                busy    = 1'b0;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Burst bookkeeping: latched command, accepted-beat count and round-robin pointer.
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_BCAST;
            len_q  <= '0;
            cnt_q  <= '0;
            ptr_q  <= '0;
        end else if (cmd_take) begin
            mode_q <= bus.cmd_mode;
            len_q  <= bus.cmd_len;
            cnt_q  <= '0;
            ptr_q  <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + WID_LEN'(1);
            if (mode_q == MODE_RR) begin
                ptr_q <= (ptr_q == WID_PTR'(N_ROW - 1)) ? '0 : ptr_q + WID_PTR'(1);
            end
        end
    end

    for (genvar i = 0; i < N_ROW; i++) begin : g_row
        assign push[i] = accept && ((mode_q == MODE_BCAST) || (ptr_q == WID_PTR'(i)));

        act_row_fifo #(
            .WIDTH (WID_BEAT),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk_l),
            .rst       (rst),
            .push      (push[i]),
            .push_data (bus.s_data),
            .full      (full[i]),
            .pop_req   (bus.act_data_in_req[i]),
            .empty     (empty[i]),
            .rd_data   (row_data[i*WID_BEAT +: WID_BEAT]),
            .rd_vld    (row_vld[i])
        );
    end

    assign bus.cmd_rdy         = cmd_rdy;
    assign bus.s_rdy           = s_rdy;
    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.fifo_empty      = empty;
    assign bus.act_data_in     = row_data;
    assign bus.act_data_in_vld = row_vld;

endmodule

// File: tb/tb_act_dispatch.sv
// tb_act_dispatch: randomized and directed stimulus against a queue-based reference model.
module tb_act_dispatch;
    import act_dispatch_pkg::*;

    localparam int N_ROW   = 3;
    localparam int WID_ACT = 16;
    localparam int DEPTH   = 4;
    localparam int WID_LEN = 12;
    localparam int WB      = 2 * WID_ACT;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic clk_l = 1'b0;
    logic rst;
    always #5 clk_l = ~clk_l;

    act_dispatch_if #(.N_ROW(N_ROW), .WID_ACT(WID_ACT), .WID_LEN(WID_LEN)) bus ();

    act_dispatch #(
        .N_ROW      (N_ROW),
        .WID_ACT    (WID_ACT),
        .FIFO_DEPTH (DEPTH),
        .WID_LEN    (WID_LEN)
    ) dut (
        .clk_l (clk_l),
        .rst   (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: burst phase, beats still owed, per-row queues of pending words.
    int    phase;
    logic  m_mode;
    int    beats_left;
    int    rr;
    int    acc_cnt;
    int    occ [N_ROW];
    beat_t q [N_ROW][$];
    beat_t exp_data [N_ROW];
    logic  exp_vld [N_ROW];
    beat_t next_beat;
    bit    rand_data;
    int    done_obs;
    int    vld_obs [N_ROW];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_s_rdy();
        if (phase != PH_RUN) return 1'b0;
        if (m_mode == MODE_BCAST) begin
            for (int i = 0; i < N_ROW; i++) if (occ[i] >= DEPTH) return 1'b0;
            return 1'b1;
        end
        return (occ[rr] < DEPTH);
    endfunction

    task automatic model_reset();
        phase = PH_IDLE;
        rr = 0;
        beats_left = 0;
        acc_cnt = 0;
        for (int i = 0; i < N_ROW; i++) begin
            occ[i] = 0;
            q[i].delete();
            exp_data[i] = '0;
            exp_vld[i] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("cmd_rdy", bus.cmd_rdy, phase == PH_IDLE);
        check("busy", bus.busy, phase != PH_IDLE);
        check("done", bus.done, phase == PH_DONE);
        check("s_rdy", bus.s_rdy, exp_s_rdy());
        if (bus.done) done_obs++;
        for (int i = 0; i < N_ROW; i++) begin
            check($sformatf("fifo_empty%0d", i), bus.fifo_empty[i], occ[i] == 0);
            check($sformatf("vld%0d", i), bus.act_data_in_vld[i], exp_vld[i]);
            check($sformatf("data%0d", i), bus.act_data_in[i*WB +: WB], exp_data[i]);
            if (bus.act_data_in_vld[i]) vld_obs[i]++;
        end
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_step();
        logic acc;
        logic take;
        acc  = bus.s_vld && exp_s_rdy();
        take = bus.cmd_en && (phase == PH_IDLE);
        for (int i = 0; i < N_ROW; i++) begin
            exp_vld[i] = 1'b0;
            if (bus.act_data_in_req[i] && occ[i] > 0) begin
                exp_data[i] = q[i].pop_front();
                occ[i]--;
                exp_vld[i] = 1'b1;
            end
        end
        if (acc) begin
            if (m_mode == MODE_BCAST) begin
                for (int i = 0; i < N_ROW; i++) begin
                    q[i].push_back(bus.s_data);
                    occ[i]++;
                end
            end else begin
                q[rr].push_back(bus.s_data);
                occ[rr]++;
                rr = (rr + 1) % N_ROW;
            end
            acc_cnt++;
            next_beat = rand_data ? beat_t'($urandom) : next_beat + 1;
        end
        case (phase)
            PH_IDLE: if (take) begin
                m_mode     = bus.cmd_mode;
                beats_left = int'(bus.cmd_len);
                rr         = 0;
                acc_cnt    = 0;
                phase      = (beats_left == 0) ? PH_DONE : PH_RUN;
            end
            PH_RUN: if (acc) begin
                beats_left--;
                if (beats_left == 0) phase = PH_DONE;
            end
            default: phase = PH_IDLE;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk_l);
        check_outputs();
        model_step();
        @(posedge clk_l);
        #1;
        bus.s_data = next_beat;
    endtask

    task automatic set_req(input int kind, input int n);
        case (kind)
            0:       bus.act_data_in_req = '1;
            1:       bus.act_data_in_req = N_ROW'($urandom);
            default: bus.act_data_in_req = (n % 4 == 3) ? 3'b111 : 3'b011;
        endcase
    endtask

    // Issue a command, then stream until the burst returns to idle (or stop_at beats taken).
    task automatic run_burst(input logic mode, input int len, input int vld_pct,
                             input int req_kind, input int stop_at);
        int guard;
        guard = 0;
        bus.s_data   = next_beat;
        bus.cmd_en   = 1'b1;
        bus.cmd_mode = mode;
        bus.cmd_len  = WID_LEN'(len);
        bus.s_vld    = (vld_pct >= 100);
        set_req(req_kind, 0);
        cycle();
        bus.cmd_en = 1'b0;
        while (phase != PH_IDLE && !(stop_at >= 0 && acc_cnt >= stop_at)) begin
            if (guard > 400) begin
                check("timeout", 1'b0, 1'b1);
                break;
            end
            guard++;
            bus.s_vld = ($urandom_range(99) < vld_pct);
            set_req(req_kind, guard);
            cycle();
        end
        bus.s_vld = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.s_vld = 1'b0;
        bus.act_data_in_req = '1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_en = 1'b0;
        bus.cmd_mode = 1'b0;
        bus.cmd_len = '0;
        bus.s_data = '0;
        bus.s_vld = 1'b0;
        bus.act_data_in_req = '0;
        rand_data = 1'b0;
        next_beat = '0;
        done_obs = 0;
        model_reset();
        @(posedge clk_l);
        #1;
        check_outputs();
        rst = 1'b0;

        // Broadcast A0..A3, every row requesting.
        next_beat = beat_t'(32'hA0);
        done_obs = 0;
        run_burst(MODE_BCAST, 4, 100, 0, -1);
        drain(4);
        check("bcast_done_once", 32'(done_obs), 32'd1);
        check("bcast_beats", 32'(acc_cnt), 32'd4);

        // Round-robin 1..7 over three rows.
        next_beat = beat_t'(1);
        run_burst(MODE_RR, 7, 100, 0, -1);
        check("rr_ptr", 32'(dut.ptr_q), 32'd1);
        drain(4);

        // Broadcast with row 2 held off except one cycle in four.
        next_beat = beat_t'(32'h100);
        run_burst(MODE_BCAST, 10, 100, 2, -1);
        drain(8);

        // Zero-length command.
        done_obs = 0;
        run_burst(MODE_BCAST, 0, 100, 0, -1);
        drain(2);
        check("len0_done_once", 32'(done_obs), 32'd1);
        check("len0_beats", 32'(acc_cnt), 32'd0);

        // Requests against empty FIFOs, then a single beat.
        for (int i = 0; i < N_ROW; i++) vld_obs[i] = 0;
        drain(5);
        check("empty_req_no_vld", 32'(vld_obs[0]), 32'd0);
        next_beat = beat_t'(32'h55);
        run_burst(MODE_BCAST, 1, 100, 0, -1);
        drain(3);
        for (int i = 0; i < N_ROW; i++) check($sformatf("one_vld%0d", i), 32'(vld_obs[i]), 32'd1);

        // Reset after two of six beats, then a fresh three-beat burst.
        next_beat = beat_t'(32'h200);
        done_obs = 0;
        bus.act_data_in_req = '0;
        run_burst(MODE_BCAST, 6, 100, 1, 2);
        bus.cmd_en = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk_l);
        #1;
        rst = 1'b0;
        check("rst_no_done", 32'(done_obs), 32'd0);
        next_beat = beat_t'(32'h300);
        run_burst(MODE_BCAST, 3, 100, 0, -1);
        drain(4);
        check("post_rst_beats", 32'(acc_cnt), 32'd3);

        // Randomized bursts.
        rand_data = 1'b1;
        next_beat = beat_t'($urandom);
        for (int b = 0; b < 25; b++) begin
            run_burst(logic'($urandom_range(1)), int'($urandom_range(9)),
                      int'($urandom_range(100, 30)), 1, -1);
        end
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
